// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default sample/twiddle widths and the
// symmetric saturation helpers used by every FFT arithmetic block.
package fft_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int TW_W_DEF   = 16;

  // Largest magnitude representable in a w-bit signed word, as a 64-bit value.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Symmetric floor: the most negative code is deliberately excluded.
  function automatic logic signed [63:0] sat_min(input int w);
    return -sat_max(w);
  endfunction

  function automatic logic signed [63:0] sat_sym(input logic signed [63:0] v,
                                                 input int                 w);
    logic signed [63:0] r;
    r = v;
    if (v > sat_max(w)) begin
      r = sat_max(w);
    end else if (v < sat_min(w)) begin
      r = sat_min(w);
    end
    return r;
  endfunction

  localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = DATA_W_DEF'(sat_max(DATA_W_DEF));
  localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = DATA_W_DEF'(sat_min(DATA_W_DEF));

endpackage

// File: rtl/sat_round.sv
// Combinational arithmetic-shift / round / symmetric-saturate cell.
// Define BFLY_ROUND_EN for round-half-up shifts; otherwise shifts truncate (floor).
module sat_round
  import fft_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o,
  output logic                    sat_o
);

  localparam int EXT_W = IN_W + 1;  // one guard bit so the rounding bias cannot wrap

  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;
  logic signed [63:0]      wide;
  logic signed [63:0]      clamped;

  if (SHIFT > 0) begin : g_shift
`ifdef BFLY_ROUND_EN
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) <<< (SHIFT - 1);
    assign biased = EXT_W'(in_i) + HALF;
`else
    assign biased = EXT_W'(in_i);
`endif
    assign shifted = biased >>> SHIFT;
  end else begin : g_pass
    assign biased  = EXT_W'(in_i);
    assign shifted = biased;
  end

  assign wide    = 64'(shifted);
  assign clamped = sat_sym(wide, OUT_W);
  assign out_o   = OUT_W'(clamped);
  assign sat_o   = (clamped != wide);

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIF butterfly: ya = xa + xb, yb = (xa - xb) * w,
// stall-all valid/ready handshake, sticky ovf. Macro BFLY_ROUND_EN selects rounding.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] xa_re,
  input  logic signed [DATA_W-1:0] xa_im,
  input  logic signed [DATA_W-1:0] xb_re,
  input  logic signed [DATA_W-1:0] xb_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  input  logic                     scale,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] ya_re,
  output logic signed [DATA_W-1:0] ya_im,
  output logic signed [DATA_W-1:0] yb_re,
  output logic signed [DATA_W-1:0] yb_im,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int SUM_W  = DATA_W + 1;
  localparam int PROD_W = DATA_W + TW_W;
  localparam int ACC_W  = PROD_W + 1;

  logic adv;

  logic signed [DATA_W-1:0] xa [2];
  logic signed [DATA_W-1:0] xb [2];
  logic signed [SUM_W-1:0]  sum_w [2];
  logic signed [SUM_W-1:0]  diff_w [2];
  logic signed [SUM_W-1:0]  sum_sc [2];
  logic signed [DATA_W-1:0] sum_ns [2];
  logic signed [DATA_W-1:0] diff_sat [2];
  logic signed [DATA_W-1:0] s1_sum_d [2];
  logic [1:0]               sat_sum_ns, sat_sum_sc, sat_diff;
  logic                     s1_sat;

  logic                     s1_valid_q, s1_scale_q;
  logic signed [DATA_W-1:0] s1_sum_q [2];
  logic signed [DATA_W-1:0] s1_diff_q [2];
  logic signed [TW_W-1:0]   s1_w_q [2];

  logic signed [PROD_W-1:0] s2_prod_d [4];
  logic                     s2_valid_q, s2_scale_q;
  logic signed [DATA_W-1:0] s2_sum_q [2];
  logic signed [PROD_W-1:0] s2_prod_q [4];

  logic signed [ACC_W-1:0]  acc [2];
  logic signed [DATA_W-1:0] yb_ns [2];
  logic signed [DATA_W-1:0] yb_sc [2];
  logic signed [DATA_W-1:0] yb_d [2];
  logic [1:0]               sat_yb_ns, sat_yb_sc;
  logic                     s3_sat;

  logic                     out_valid_q;
  logic signed [DATA_W-1:0] ya_q [2];
  logic signed [DATA_W-1:0] yb_q [2];
  logic                     ovf_q, ovf_d, ovf_set;

  // Whole pipe moves together; a held output freezes every stage behind it.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign xa[0] = xa_re;
  assign xa[1] = xa_im;
  assign xb[0] = xb_re;
  assign xb[1] = xb_im;

  for (genvar i = 0; i < 2; i++) begin : g_s1
    assign sum_w[i]  = SUM_W'(xa[i]) + SUM_W'(xb[i]);
    assign diff_w[i] = SUM_W'(xa[i]) - SUM_W'(xb[i]);

    sat_round #(.IN_W(SUM_W), .OUT_W(DATA_W), .SHIFT(0)) u_sum_ns (
      .in_i(sum_w[i]), .out_o(sum_ns[i]), .sat_o(sat_sum_ns[i]));
    // Halved sum always fits DATA_W, so it is kept one bit wide and never clamps.
    sat_round #(.IN_W(SUM_W), .OUT_W(SUM_W), .SHIFT(1)) u_sum_sc (
      .in_i(sum_w[i]), .out_o(sum_sc[i]), .sat_o(sat_sum_sc[i]));
    sat_round #(.IN_W(SUM_W), .OUT_W(DATA_W), .SHIFT(0)) u_diff (
      .in_i(diff_w[i]), .out_o(diff_sat[i]), .sat_o(sat_diff[i]));

    assign s1_sum_d[i] = scale ? DATA_W'(sum_sc[i]) : sum_ns[i];
  end

  assign s1_sat = (|sat_diff) | (scale ? (|sat_sum_sc) : (|sat_sum_ns));

  assign s2_prod_d[0] = PROD_W'(s1_diff_q[0]) * PROD_W'(s1_w_q[0]);
  assign s2_prod_d[1] = PROD_W'(s1_diff_q[1]) * PROD_W'(s1_w_q[1]);
  assign s2_prod_d[2] = PROD_W'(s1_diff_q[0]) * PROD_W'(s1_w_q[1]);
  assign s2_prod_d[3] = PROD_W'(s1_diff_q[1]) * PROD_W'(s1_w_q[0]);

  assign acc[0] = ACC_W'(s2_prod_q[0]) - ACC_W'(s2_prod_q[1]);
  assign acc[1] = ACC_W'(s2_prod_q[2]) + ACC_W'(s2_prod_q[3]);

  for (genvar i = 0; i < 2; i++) begin : g_s3
    sat_round #(.IN_W(ACC_W), .OUT_W(DATA_W), .SHIFT(TW_W - 1)) u_yb_ns (
      .in_i(acc[i]), .out_o(yb_ns[i]), .sat_o(sat_yb_ns[i]));
    sat_round #(.IN_W(ACC_W), .OUT_W(DATA_W), .SHIFT(TW_W)) u_yb_sc (
      .in_i(acc[i]), .out_o(yb_sc[i]), .sat_o(sat_yb_sc[i]));

    assign yb_d[i] = s2_scale_q ? yb_sc[i] : yb_ns[i];
  end

  assign s3_sat  = s2_scale_q ? (|sat_yb_sc) : (|sat_yb_ns);
  assign ovf_set = adv && ((in_valid && s1_sat) || (s2_valid_q && s3_sat));

  // NOTE: datapath registers are reset as well as the valids, because the
  // y* outputs must read zero while and after reset is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_scale_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_scale_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        s1_sum_q[i]  <= '0;
        s1_diff_q[i] <= '0;
        s1_w_q[i]    <= '0;
        s2_sum_q[i]  <= '0;
        ya_q[i]      <= '0;
        yb_q[i]      <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        s2_prod_q[k] <= '0;
      end
    end else if (adv) begin
      // NOTE: non-blocking assignments so each stage captures the previous
      // stage's pre-edge contents, regardless of statement order.
      s1_valid_q  <= in_valid;
      s1_scale_q  <= scale;
      s1_w_q[0]   <= w_re;
      s1_w_q[1]   <= w_im;
      s2_valid_q  <= s1_valid_q;
      s2_scale_q  <= s1_scale_q;
      out_valid_q <= s2_valid_q;
      for (int i = 0; i < 2; i++) begin
        s1_sum_q[i]  <= s1_sum_d[i];
        s1_diff_q[i] <= diff_sat[i];
        s2_sum_q[i]  <= s1_sum_q[i];
        ya_q[i]      <= s2_sum_q[i];
        yb_q[i]      <= yb_d[i];
      end
      for (int k = 0; k < 4; k++) begin
        s2_prod_q[k] <= s2_prod_d[k];
      end
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves ovf_d unassigned (no latch).
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign out_valid = out_valid_q;
  assign ya_re     = ya_q[0];
  assign ya_im     = ya_q[1];
  assign yb_re     = yb_q[0];
  assign yb_im     = yb_q[1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed, table-driven bench for butterfly_pipe plus multi-cycle sequences
// (backpressure, mid-flight reset, simultaneous ovf set/clear).
module tb_butterfly_pipe;
  import fft_pkg::*;

`ifdef BFLY_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready, scale, out_valid, out_ready, ovf, ovf_clr;
  logic [15:0] xa_re, xa_im, xb_re, xb_im, w_re, w_im;
  logic [15:0] ya_re, ya_im, yb_re, yb_im;

  butterfly_pipe #(.DATA_W(16), .TW_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .xa_re(xa_re), .xa_im(xa_im), .xb_re(xb_re), .xb_im(xb_im),
    .w_re(w_re), .w_im(w_im), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .ya_re(ya_re), .ya_im(ya_im), .yb_re(yb_re), .yb_im(yb_im),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] xa_re, xa_im, xb_re, xb_im, w_re, w_im;
    logic        scale, clr_before;
    logic [15:0] ya_re, ya_im, yb_re, yb_im;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_beat(input vec_t v);
    xa_re = v.xa_re; xa_im = v.xa_im; xb_re = v.xb_re; xb_im = v.xb_im;
    w_re  = v.w_re;  w_im  = v.w_im;  scale = v.scale; in_valid = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
  endtask

  // Sends one beat into an empty pipe and checks latency, results and ovf.
  task automatic run_vec(input int idx);
    vec_t v;
    int   lat;
    v = vecs[idx];
    if (v.clr_before) pulse_clr();
    @(negedge clk);
    drive_beat(v);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check($sformatf("v%0d_latency", idx), lat, 3);
    check($sformatf("v%0d_ya_re", idx), ya_re, v.ya_re);
    check($sformatf("v%0d_ya_im", idx), ya_im, v.ya_im);
    check($sformatf("v%0d_yb_re", idx), yb_re, v.yb_re);
    check($sformatf("v%0d_yb_im", idx), yb_im, v.yb_im);
    check($sformatf("v%0d_ovf", idx), ovf, v.ovf);
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check(name, out_valid, 1'b1);
  endtask

  initial begin
    int sent, got;

    //          xa_re    xa_im    xb_re    xb_im    w_re     w_im     sc    clr   ya_re  ya_im  yb_re  yb_im  ovf
    vecs[0] = '{16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b1,
                16'h6000, 16'h0000, RND ? 16'h2000 : 16'h1FFF, 16'h0000, 1'b0};
    vecs[1] = '{16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b1,
                SAT_MAX, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[2] = '{16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0,
                16'h7000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[3] = '{16'h9000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b1,
                16'h0000, 16'h0000, RND ? 16'h8002 : 16'h8001, 16'h0000, 1'b1};
    vecs[4] = '{16'h1000, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b1,
                16'h1000, 16'h0800, 16'h0800, 16'hF000, 1'b0};
    vecs[5] = '{16'h1000, 16'h2000, 16'h0400, 16'hFC00, 16'h4000, 16'h4000, 1'b1, 1'b1,
                16'h0A00, 16'h0E00, 16'hFA00, 16'h0C00, 1'b0};
    vecs[6] = '{16'h0003, 16'hFFFD, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b1,
                RND ? 16'h0002 : 16'h0001, RND ? 16'hFFFF : 16'hFFFE,
                16'h0001, RND ? 16'hFFFF : 16'hFFFE, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 1'b0, 1'b1,
                16'h7FFF, 16'h7FFF, SAT_MIN, 16'hFFFF, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0; scale = 1'b0;
    xa_re = '0; xa_im = '0; xb_re = '0; xb_im = '0; w_re = '0; w_im = '0;

    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_ya_re", ya_re, 16'h0);
    check("rst_yb_im", yb_im, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 8; i++) run_vec(i);
    pulse_clr();
    check("ovf_cleared", ovf, 1'b0);

    // A saturating beat accepted in the same cycle as ovf_clr must leave ovf set.
    @(negedge clk);
    drive_beat(vecs[1]);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0; in_valid = 1'b0;
    check("ovf_set_wins", ovf, 1'b1);
    wait_out("setclr_out_valid");
    check("setclr_ya_re", ya_re, SAT_MAX);
    pulse_clr();

    // Backpressure: 6 beats back-to-back, out_ready low for cycles 4..7.
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 8);
      if (sent < 6) begin
        xa_re = 16'(16'h0100 * (sent + 1)); xa_im = 16'(16'h0010 * (sent + 1));
        xb_re = 16'h0; xb_im = 16'h0; w_re = 16'h4000; w_im = 16'h0; scale = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        check($sformatf("bp_ya_re_%0d", got), ya_re, 16'(16'h0100 * (got + 1)));
        check($sformatf("bp_ya_im_%0d", got), ya_im, 16'(16'h0010 * (got + 1)));
        check($sformatf("bp_yb_re_%0d", got), yb_re, 16'(16'h0080 * (got + 1)));
        check($sformatf("bp_yb_im_%0d", got), yb_im, 16'(16'h0008 * (got + 1)));
        if (!out_ready) check($sformatf("bp_in_ready_c%0d", cyc), in_ready, 1'b0);
        else got++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", got, 6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_no_dup_%0d", i), out_valid, 1'b0);
    end

    // Reset with beats in flight: ovf and outputs are non-zero beforehand.
    run_vec(1);
    @(negedge clk); drive_beat(vecs[0]);
    @(negedge clk); drive_beat(vecs[5]);
    @(negedge clk); drive_beat(vecs[4]);
    @(posedge clk);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_ovf", ovf, 1'b0);
    check("mrst_ya_re", ya_re, 16'h0);
    check("mrst_ya_im", ya_im, 16'h0);
    check("mrst_yb_re", yb_re, 16'h0);
    check("mrst_yb_im", yb_im, 16'h0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mrst_no_ghost_%0d", i), out_valid, 1'b0);
    end
    run_vec(0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Parametrised, fully pipelined radix-2 DIF butterfly: Xa = xa + xb, Xb = (xa - xb) * W.
- Generalises the single-stage 16-bit butterfly:
  - Data and twiddle widths are parameters.
  - Adds a valid/ready handshake with backpressure.
  - Adds optional per-stage divide-by-2 scaling.
  - Adds a sticky saturation flag.
- Sits between the FFT stage memory read port and the write-back path. Twiddle comes from the twiddle ROM, aligned with the input data.

Parameters:
- DATA_W, 16, signed sample width (re and im each), Q1.(DATA_W-1).
- TW_W, 16, signed twiddle width, Q1.(TW_W-1); -1.0 is representable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- xa_re, xa_im, xb_re, xb_im  in  DATA_W each  signed input operands.
- w_re, w_im  in  TW_W each  signed twiddle.
- scale  in  1  sampled with the beat; 1 = halve both outputs.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- ya_re, ya_im, yb_re, yb_im  out  DATA_W each  registered results.
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valids = 0, out_valid = 0, ovf = 0, all y* = 0.
  - Any beats in flight are discarded.
- Pipeline, 3 stages, latency 3 cycles from accept to out_valid when not stalled:
  - S1: sum = xa + xb and diff = xa - xb at DATA_W+1 bits.
    - Sum: if scale=1, arithmetic shift right by 1 (round per macro), never saturates. If scale=0, saturate to DATA_W.
    - Diff: always saturated to DATA_W. Register sum, diff, w, scale.
  - S2: four products, each DATA_W+TW_W bits signed: d_re*w_re, d_im*w_im, d_re*w_im, d_im*w_re. Registered. Sum is delayed alongside.
  - S3: re = p1 - p2, im = p3 + p4 at DATA_W+TW_W+1 bits.
    - Shift right by (TW_W-1), plus 1 more if scale=1. Round per macro, then saturate to DATA_W.
    - Register yb; ya is registered in the same cycle.
- Saturation is symmetric: clamp to +(2^(DATA_W-1)-1) and -(2^(DATA_W-1)-1). The most negative code is never produced by saturation.
- Handshake:
  - Stall-all pipeline: adv = !out_valid || out_ready; in_ready = adv.
  - Accept when in_valid && in_ready. Stage registers and valids load only when adv=1.
  - While out_valid=1 && out_ready=0: outputs and all stage contents hold unchanged.
  - Full throughput of 1 beat/cycle when out_ready is held high.
  - No beat is lost or duplicated, and order is preserved.
- ovf:
  - Set on any saturation event in S1 or S3 for a valid beat, in the cycle that stage advances.
  - ovf_clr clears it. If set and clear occur in the same cycle, set wins.
- Bubbles (stage valid=0) never set ovf; their data contents are don't-care.
- scale travels with its beat. Changing scale between beats has no effect on beats already in flight.

Optional Feature:
- Macro: BFLY_ROUND_EN.
- Defined: every right shift (scale in S1, product rescale in S3) adds half-LSB (1 << (shift-1)) before an arithmetic shift, i.e. round-half-up, then saturates.
- Undefined: plain arithmetic shift (floor/truncate), matching the legacy butterfly numerics. Latency and ports are identical in both builds.

Decomposition:
- Package fft_pkg: default DATA_W/TW_W constants, SAT_MAX/SAT_MIN derivation, and the symmetric saturate function shared with other FFT blocks.
- One sub-module, sat_round: a parametrised (IN_W, OUT_W, SHIFT) combinational shift-round-saturate cell that also outputs a sat flag. It is instantiated for sum, diff and both S3 results.

Test Plan:
- Basic beat: xa=(0x4000,0), xb=(0x2000,0), w=(0x7FFF,0), scale=0. Expected 3 cycles later: ya=(0x6000,0); yb_re=0x2000 with BFLY_ROUND_EN, 0x1FFF without; ovf=0.
- Sum overflow: xa_re=xb_re=0x7000, scale=0 → ya_re=0x7FFF, ovf=1. Same beat with scale=1 → ya_re=0x7000, ovf unchanged. Then ovf_clr pulse → ovf=0.
- Diff underflow and -j twiddle:
  - xa_re=-0x7000, xb_re=0x7000 → diff saturates to 0x8001, ovf=1.
  - Separately, diff=(0x1000,0x0800) with w=(0x0000,0x8000) → yb=(0x0800,0xF000).
- Backpressure: stream 6 beats back-to-back; drop out_ready for 4 cycles mid-stream. Expect in_ready=0 while the pipe is full and outputs stable. All 6 results arrive in order, with none lost or duplicated.
- Reset mid-operation: assert rst_n=0 asynchronously with 2 beats in flight. Expect out_valid=0, ovf=0 and y*=0 immediately. After release, a new beat appears after 3 cycles with correct values.
- Simultaneous ovf set/clear: a saturating beat advances in the same cycle ovf_clr=1 → ovf=1 next cycle.
